// File: rtl/ecg_window_buffer.sv
// ecg_window_buffer
// Ping-pong window buffer between the downsampler and the LSTM feature front-end.
// Each (g, f) sample pair strobed by in_valid goes into the current write bank.
// A bank that holds a complete window of WIN_LEN samples is marked full and then
// streamed out over a valid/ready handshake while the other bank keeps filling.
// A sample is dropped, and overflow set, only when both banks are full.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   clk_enable           global advance enable; all state frozen when low
//   in_valid, in_g, in_f sample strobe and signed sample pair
//   out_valid, out_ready output handshake
//   out_g, out_f         signed window sample pair
//   out_idx, out_last    beat position within window, last-beat marker
//   overflow             sticky: at least one sample dropped since reset
//   drop_count           saturating count of dropped samples
//                        (present only when ECG_WIN_DROP_CNT_EN is defined)
module ecg_window_buffer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned WIN_LEN = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clk_enable,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_g,
    input  logic signed [DATA_W-1:0]   in_f,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_g,
    output logic signed [DATA_W-1:0]   out_f,
    output logic [$clog2(WIN_LEN)-1:0] out_idx,
    output logic                       out_last,
    output logic                       overflow
`ifdef ECG_WIN_DROP_CNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    localparam int unsigned AW = $clog2(WIN_LEN);
    localparam logic [AW-1:0] LastIdx = AW'(WIN_LEN - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

    // Storage: two banks, no reset (contents are don't-care after reset)
    logic signed [DATA_W-1:0] mem_g [2][WIN_LEN];
    logic signed [DATA_W-1:0] mem_f [2][WIN_LEN];

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    state_e        state_q, state_d;

    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_g_q, out_g_d;
    logic signed [DATA_W-1:0] out_f_q, out_f_d;
    logic [AW-1:0]            out_idx_q, out_idx_d;
    logic                     out_last_q, out_last_d;
    logic                     overflow_q, overflow_d;

    logic wr_fire, wr_drop, wr_done, clr_full;

    // Full flag of the write bank is sampled pre-edge, so a bank being freed on
    // this same edge still causes the incoming sample to be dropped.
    assign wr_fire = clk_enable & in_valid & ~full_q[wr_bank_q];
    assign wr_drop = clk_enable & in_valid &  full_q[wr_bank_q];
    assign wr_done = wr_fire & (wr_idx_q == LastIdx);

    // Write side
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_idx_d   = wr_idx_q;
        overflow_d = overflow_q | wr_drop;
        if (wr_fire) begin
            if (wr_done) begin
                wr_idx_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    // Full flags: set and clear always target different banks (the write bank
    // is never full, the read bank always is while streaming).
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (clr_full) full_d[rd_bank_q] = 1'b0;
    end

    // Read FSM and output registers
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_g_d     = out_g_q;
        out_f_d     = out_f_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        clr_full    = 1'b0;
        if (clk_enable) begin
            unique case (state_q)
                StIdle: begin
                    if (full_q[rd_bank_q]) state_d = StLoad;
                end
                StLoad: begin
                    out_valid_d = 1'b1;
                    out_g_d     = mem_g[rd_bank_q][0];
                    out_f_d     = mem_f[rd_bank_q][0];
                    out_idx_d   = '0;
                    out_last_d  = 1'b0;
                    rd_idx_d    = AW'(1);
                    state_d     = StStream;
                end
                StStream: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            clr_full    = 1'b1;
                            rd_bank_d   = ~rd_bank_q;
                            rd_idx_d    = '0;
                            state_d     = StIdle;
                        end else begin
                            // rd_idx_q already points at the next beat: no bubble
                            out_g_d    = mem_g[rd_bank_q][rd_idx_q];
                            out_f_d    = mem_f[rd_bank_q][rd_idx_q];
                            out_idx_d  = rd_idx_q;
                            out_last_d = (rd_idx_q == LastIdx);
                            rd_idx_d   = (rd_idx_q == LastIdx) ? '0 : rd_idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_g[wr_bank_q][wr_idx_q] <= in_g;
            mem_f[wr_bank_q][wr_idx_q] <= in_f;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_g_q     <= '0;
            out_f_q     <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_g_q     <= out_g_d;
            out_f_q     <= out_f_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_g     = out_g_q;
    assign out_f     = out_f_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

`ifdef ECG_WIN_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else if (wr_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
